// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if
// Request/response bus of the data memory controller.
//   master modport : request side (drives req_*, observes ready and response)
//   slave modport  : memory side (drives req_ready, resp_*, init_done)
// Handshake: a request transfers on the rising clk edge where req_valid and
// req_ready are both 1; req_ready is low while a request is outstanding or
// during initialisation. resp_valid is a one-cycle strobe that qualifies
// resp_rdata/resp_err; those hold their last values otherwise.
interface data_memory_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_done;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, init_done
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
// Byte-addressed 32-bit data memory with RV32I load/store widths, a
// post-reset initialisation sweep (word i = i + INIT_OFFSET), one outstanding
// request and a fixed response latency of LATENCY cycles after acceptance.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   bus         : request/response bus (slave side)
//   dbg_state_o : current FSM state (0=INIT, 1=IDLE, 2=WAIT)
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter int INIT_OFFSET = 3
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_ctrl_if.slave  bus,
    output logic [1:0]         dbg_state_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    logic [31:0]   mem_q [DEPTH_WORDS];
    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [2:0]    lat_cnt_q;
    logic          we_q, err_q;
    logic [2:0]    f3_q;
    logic [AW-1:0] word_q;
    logic [1:0]    off_q;
    logic          req_ready_q, resp_valid_q, resp_err_q, init_done_q;
    logic [31:0]   resp_rdata_q;

    // Request decode (combinational on the live bus, used only at accept).
    logic          accept;
    logic [AW-1:0] req_word;
    logic [1:0]    req_off;
    logic          oor, mis_h, mis_w, bad_f3, req_err;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;

    assign accept   = req_ready_q && bus.req_valid;
    assign req_word = bus.req_addr[AW+1:2];
    assign req_off  = bus.req_addr[1:0];
    assign oor      = |bus.req_addr[31:AW+2];
    assign mis_h    = (bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0];
    assign mis_w    = (bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00);
    assign bad_f3   = bus.req_we ? (bus.req_funct3 > 3'b010)
                                 : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
    assign req_err  = oor || mis_h || mis_w || bad_f3;

    // Store lanes: data is replicated so each enabled byte lane picks its slice.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << req_off;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be        = req_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Memory array: init sweep writes, otherwise error-free stores on accept.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[cnt_q] <= 32'(cnt_q) + 32'(INIT_OFFSET);
        end else if (accept && bus.req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[req_word][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // Load formatting. No store can land while a request is outstanding, so
    // reading the array at response time equals the post-accept contents.
    logic [31:0] rd_word, rd_sh, load_data;
    assign rd_word = mem_q[word_q];
    assign rd_sh   = rd_word >> {off_q, 3'b000};

    always_comb begin
        load_data = 32'h0;
        if (!we_q && !err_q) begin
            case (f3_q)
                3'b000:  load_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
                3'b001:  load_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
                3'b010:  load_data = rd_word;
                3'b100:  load_data = {24'h0, rd_sh[7:0]};
                3'b101:  load_data = {16'h0, rd_sh[15:0]};
                default: load_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            lat_cnt_q    <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            f3_q         <= 3'b000;
            word_q       <= '0;
            off_q        <= 2'b00;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                        req_ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_WAIT;
                        req_ready_q <= 1'b0;
                        lat_cnt_q   <= 3'(LATENCY - 1);
                        we_q        <= bus.req_we;
                        err_q       <= req_err;
                        f3_q        <= bus.req_funct3;
                        word_q      <= req_word;
                        off_q       <= req_off;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == 3'd0) begin
                        state_q      <= S_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                        resp_err_q   <= err_q;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.init_done  = init_done_q;
    assign dbg_state_o    = state_q;
endmodule
